// File: rtl/ysyx_23060303_pkg.sv
// Shared decode constants, FSM states and halt codes for the multi-cycle core.
package ysyx_23060303_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {FETCH, WAIT, EXEC, HALT} state_e;

  localparam logic [1:0] HC_RUN         = 2'b00;
  localparam logic [1:0] HC_EBREAK_ZERO = 2'b01;
  localparam logic [1:0] HC_EBREAK_NZ   = 2'b10;
  localparam logic [1:0] HC_FAULT       = 2'b11;

endpackage

// File: rtl/ysyx_23060303_regfile_p.sv
// Parametrised integer register file: two asynchronous reads, one synchronous write, x0 reads as zero.
module ysyx_23060303_regfile_p #(
  parameter int unsigned NR_REG = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  localparam int unsigned AW = $clog2(NR_REG);

  logic [31:0] regs [NR_REG];

  // Clear on reset; write only to existing, non-zero registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NR_REG; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0) && (32'(waddr) < NR_REG)) begin
      regs[waddr[AW-1:0]] <= wdata;
    end
  end

  assign rdata1 = ((raddr1 != 5'd0) && (32'(raddr1) < NR_REG)) ? regs[raddr1[AW-1:0]] : '0;
  assign rdata2 = ((raddr2 != 5'd0) && (32'(raddr2) < NR_REG)) ? regs[raddr2[AW-1:0]] : '0;

endmodule

// File: rtl/ysyx_23060303_mcore.sv
// Multi-cycle RV32I/RV32E core: FETCH -> WAIT -> EXEC per instruction, halts on ebreak or fault.
module ysyx_23060303_mcore
  import ysyx_23060303_pkg::*;
#(
  parameter int unsigned NR_REG   = 32,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_inst,
  output logic [31:0] pc,
  output logic        commit_valid,
  output logic [31:0] commit_pc,
  output logic        halt,
  output logic [1:0]  halt_code
);

  state_e      state, state_nx;
  logic [31:0] ir;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2, rf_raddr1;
  logic [31:0] imm_i, imm_u, imm_j;
  logic [31:0] rs1_data, rs2_data;
  logic        is_ebreak, legal, wr_en, jump, fault, do_commit;
  logic [31:0] wr_data, npc;

  function automatic logic reg_ok(input logic [4:0] idx);
    return 32'(idx) < NR_REG;
  endfunction

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];
  assign imm_i  = {{20{ir[31]}}, ir[31:20]};
  assign imm_u  = {ir[31:12], 12'h000};
  assign imm_j  = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};

  assign is_ebreak = (ir == INST_EBREAK);
  // ebreak carries no register fields, so port 1 is borrowed to read a0 for the halt code.
  assign rf_raddr1 = is_ebreak ? 5'd10 : rs1;

  ysyx_23060303_regfile_p #(.NR_REG(NR_REG)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rf_raddr1),
    .rdata1 (rs1_data),
    .raddr2 (rs2),
    .rdata2 (rs2_data),
    .we     (do_commit && wr_en),
    .waddr  (rd),
    .wdata  (wr_data)
  );

  // Decode, ALU and next-PC for the instruction held in IR.
  always_comb begin
    legal   = 1'b0;
    wr_en   = 1'b1;
    wr_data = '0;
    npc     = pc + 32'd4;
    jump    = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        legal   = (funct3 == F3_ADD) && reg_ok(rd) && reg_ok(rs1);
        wr_data = rs1_data + imm_i;
      end
      OPC_OP: begin
        legal   = (funct3 == F3_ADD) && ((funct7 == F7_ADD) || (funct7 == F7_SUB))
                  && reg_ok(rd) && reg_ok(rs1) && reg_ok(rs2);
        wr_data = (funct7 == F7_SUB) ? rs1_data - rs2_data : rs1_data + rs2_data;
      end
      OPC_LUI: begin
        legal   = reg_ok(rd);
        wr_data = imm_u;
      end
      OPC_AUIPC: begin
        legal   = reg_ok(rd);
        wr_data = pc + imm_u;
      end
      OPC_JAL: begin
        legal   = reg_ok(rd);
        wr_data = pc + 32'd4;
        npc     = pc + imm_j;
        jump    = 1'b1;
      end
      OPC_JALR: begin
        legal   = (funct3 == F3_JALR) && reg_ok(rd) && reg_ok(rs1);
        wr_data = pc + 32'd4;
        npc     = (rs1_data + imm_i) & ~32'd1;
        jump    = 1'b1;
      end
      OPC_SYSTEM: begin
        legal = is_ebreak;
        wr_en = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    fault     = !legal || (jump && npc[1]);
    do_commit = (state == EXEC) && !fault;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_nx;
  end

  // Next-state logic and fetch request.
  always_comb begin
    state_nx       = state;
    imem_req_valid = 1'b0;
    case (state)
      FETCH: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_nx = WAIT;
      end
      WAIT:    if (imem_rsp_valid) state_nx = EXEC;
      EXEC:    state_nx = (fault || is_ebreak) ? HALT : FETCH;
      default: state_nx = HALT;
    endcase
  end

  assign imem_addr = pc;

  // IR capture, PC update and registered commit/halt reporting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir           <= '0;
      pc           <= RESET_PC;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      halt         <= 1'b0;
      halt_code    <= HC_RUN;
    end else begin
      commit_valid <= 1'b0;
      if ((state == WAIT) && imem_rsp_valid) ir <= imem_rsp_inst;
      if (state == EXEC) begin
        if (fault) begin
          halt      <= 1'b1;
          halt_code <= HC_FAULT;
        end else begin
          commit_valid <= 1'b1;
          commit_pc    <= pc;
          if (is_ebreak) begin
            halt      <= 1'b1;
            halt_code <= (rs1_data == '0) ? HC_EBREAK_ZERO : HC_EBREAK_NZ;
          end else begin
            pc <= npc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060303_mcore.sv
// Directed bench for the multi-cycle core with an ISA-level reference model and a per-cycle checker.
module tb_ysyx_23060303_mcore;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ready, rsp_valid, sel;
  logic [31:0] rsp_inst;

  logic        a_req_valid, a_cv, a_halt, e_req_valid, e_cv, e_halt;
  logic [31:0] a_addr, a_pc, a_cpc, e_addr, e_pc, e_cpc;
  logic [1:0]  a_hc, e_hc;

  ysyx_23060303_mcore #(.NR_REG(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .imem_req_valid(a_req_valid), .imem_req_ready(ready),
    .imem_addr(a_addr), .imem_rsp_valid(rsp_valid), .imem_rsp_inst(rsp_inst),
    .pc(a_pc), .commit_valid(a_cv), .commit_pc(a_cpc), .halt(a_halt), .halt_code(a_hc)
  );

  ysyx_23060303_mcore #(.NR_REG(16), .RESET_PC(RPC)) dut_e (
    .clk(clk), .rst(rst), .imem_req_valid(e_req_valid), .imem_req_ready(ready),
    .imem_addr(e_addr), .imem_rsp_valid(rsp_valid), .imem_rsp_inst(rsp_inst),
    .pc(e_pc), .commit_valid(e_cv), .commit_pc(e_cpc), .halt(e_halt), .halt_code(e_hc)
  );

  logic        req_v, cv_w, halt_w;
  logic [31:0] addr_w, pc_w, cpc_w;
  logic [1:0]  hc_w;
  assign req_v  = sel ? e_req_valid : a_req_valid;
  assign cv_w   = sel ? e_cv        : a_cv;
  assign halt_w = sel ? e_halt      : a_halt;
  assign addr_w = sel ? e_addr      : a_addr;
  assign pc_w   = sel ? e_pc        : a_pc;
  assign cpc_w  = sel ? e_cpc       : a_cpc;
  assign hc_w   = sel ? e_hc        : a_hc;

  // ---------------- program memory and ISA-level model ----------------
  logic [31:0] prog [16];
  int unsigned m_nreg;
  logic [31:0] mreg [32];
  logic [31:0] exp_cpc [64];
  logic [31:0] exp_npc [64];
  int          n_exp;
  logic [1:0]  exp_code;
  logic [31:0] exp_final_pc;

  function automatic logic [31:0] fetch_word(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - RPC;
    if ((off >= 32'd64) || (off[1:0] != 2'b00)) return 32'h0;
    return prog[off[5:2]];
  endfunction

  task automatic model_run();
    logic [31:0] p, ins, val, np, a, b, imm_i, imm_j;
    logic        ok, wr, jmp, brk;
    logic [4:0]  rd, rs1, rs2;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    p = RPC; n_exp = 0; exp_code = 2'b00; exp_final_pc = RPC;
    for (int k = 0; k < 60; k++) begin
      ins = fetch_word(p);
      rd = ins[11:7]; rs1 = ins[19:15]; rs2 = ins[24:20];
      a = mreg[rs1]; b = mreg[rs2];
      imm_i = {{20{ins[31]}}, ins[31:20]};
      imm_j = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      ok = 1'b1; wr = 1'b1; jmp = 1'b0; brk = 1'b0; val = '0; np = p + 32'd4;
      if (ins == 32'h0010_0073) begin
        wr = 1'b0; brk = 1'b1;
      end else begin
        case (ins[6:0])
          7'h13: begin
            ok  = (ins[14:12] == 3'd0) && (32'(rd) < m_nreg) && (32'(rs1) < m_nreg);
            val = a + imm_i;
          end
          7'h33: begin
            ok  = (ins[14:12] == 3'd0) && ((ins[31:25] == 7'h00) || (ins[31:25] == 7'h20))
                  && (32'(rd) < m_nreg) && (32'(rs1) < m_nreg) && (32'(rs2) < m_nreg);
            val = ins[30] ? a - b : a + b;
          end
          7'h37: begin ok = 32'(rd) < m_nreg; val = {ins[31:12], 12'h000}; end
          7'h17: begin ok = 32'(rd) < m_nreg; val = p + {ins[31:12], 12'h000}; end
          7'h6F: begin ok = 32'(rd) < m_nreg; val = p + 32'd4; np = p + imm_j; jmp = 1'b1; end
          7'h67: begin
            ok  = (ins[14:12] == 3'd0) && (32'(rd) < m_nreg) && (32'(rs1) < m_nreg);
            val = p + 32'd4; np = (a + imm_i) & ~32'd1; jmp = 1'b1;
          end
          default: ok = 1'b0;
        endcase
      end
      if (!ok || (jmp && np[1])) begin
        exp_code = 2'b11; exp_final_pc = p;
        return;
      end
      exp_cpc[n_exp] = p;
      if (wr && (rd != 5'd0)) mreg[rd] = val;
      if (brk) begin
        exp_code = (mreg[10] == 32'd0) ? 2'b01 : 2'b10;
        n_exp++;
        return;
      end
      exp_npc[n_exp] = np;
      n_exp++;
      p = np;
    end
  endtask

  // ---------------- directed checks queued for the compare process ----------------
  string       req_name [128];
  logic [31:0] req_act  [128];
  logic [31:0] req_exp  [128];
  int          req_wr = 0;

  task automatic post(input string n, input logic [31:0] act, input logic [31:0] exp);
    if (req_wr < 128) begin
      req_name[req_wr] = n; req_act[req_wr] = act; req_exp[req_wr] = exp;
      req_wr++;
    end
  endtask

  // ---------------- compare process ----------------
  int          checks = 0, errors = 0, ncommit = 0, ci = 0, req_rd = 0;
  logic        halted_prev = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_addr = '0, held_pc = '0;
  logic [1:0]  held_code = '0;

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    while (req_rd < req_wr) begin
      cmp(req_name[req_rd], req_act[req_rd], req_exp[req_rd]);
      req_rd++;
    end
    if (!rst) begin
      ncommit = 0; ci = 0; halted_prev = 1'b0; prev_stall = 1'b0;
    end else begin
      if (req_v) cmp("addr_eq_pc", addr_w, pc_w);
      if (prev_stall) begin
        cmp("stall_valid", 32'(req_v), 32'd1);
        cmp("stall_addr", addr_w, prev_addr);
      end
      prev_stall = req_v && !ready;
      prev_addr  = addr_w;
      if (!halt_w) cmp("code_running", 32'(hc_w), 32'd0);
      if (cv_w) begin
        ncommit++;
        if (ci >= n_exp) cmp("commit_count", 32'(ncommit), 32'(n_exp));
        else begin
          cmp("commit_pc", cpc_w, exp_cpc[ci]);
          if (!halt_w) cmp("next_pc", pc_w, exp_npc[ci]);
          ci++;
        end
      end
      if (halt_w && !halted_prev) begin
        cmp("halt_code", 32'(hc_w), 32'(exp_code));
        cmp("halt_with_commit", 32'(cv_w), 32'(exp_code != 2'b11));
        cmp("commits_at_halt", 32'(ncommit), 32'(n_exp));
        if (exp_code == 2'b11) cmp("fault_pc", pc_w, exp_final_pc);
        held_pc = pc_w; held_code = hc_w;
      end
      if (halted_prev) begin
        cmp("halt_sticky", 32'(halt_w), 32'd1);
        cmp("halt_pc_frozen", pc_w, held_pc);
        cmp("halt_code_frozen", 32'(hc_w), 32'(held_code));
        cmp("halt_no_commit", 32'(cv_w), 32'd0);
        cmp("halt_no_req", 32'(req_v), 32'd0);
      end
      halted_prev = halt_w;
    end
  end

  // ---------------- stimulus ----------------
  int          cyc = 0;
  logic [31:0] fetch_log [64];
  int          n_fetch;

  task automatic step();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic do_reset(input logic s);
    rst = 1'b0; ready = 1'b0; rsp_valid = 1'b0; rsp_inst = '0; sel = s;
    repeat (3) step();
    rst = 1'b1;
  endtask

  task automatic load(input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2, input logic [31:0] w3);
    for (int i = 0; i < 16; i++) prog[i] = '0;
    prog[0] = w0; prog[1] = w1; prog[2] = w2; prog[3] = w3;
  endtask

  // Acts as instruction memory until halt or the cycle budget runs out.
  task automatic serve(input int rdly, input int sdly, input int budget);
    int          start;
    logic [31:0] a;
    start = cyc; n_fetch = 0;
    while (!halt_w && ((cyc - start) < budget)) begin
      if (req_v) begin
        ready = 1'b0;
        for (int i = 0; i < rdly; i++) step();
        ready = 1'b1; a = addr_w;
        if (n_fetch < 64) begin fetch_log[n_fetch] = a; n_fetch++; end
        step();
        ready = 1'b0;
        for (int i = 0; i < sdly; i++) step();
        rsp_valid = 1'b1; rsp_inst = fetch_word(a);
        step();
        rsp_valid = 1'b0;
      end else begin
        step();
      end
    end
    if (!halt_w) post("serve_timeout", 32'(halt_w), 32'd1);
    step(); step();
  endtask

  initial begin
    rst = 1'b0; ready = 1'b0; rsp_valid = 1'b0; rsp_inst = '0; sel = 1'b0; m_nreg = 32;
    for (int i = 0; i < 16; i++) prog[i] = '0;

    // Reset state, released with ready high.
    ready = 1'b1;
    repeat (3) step();
    post("rst_pc_in_reset", pc_w, RPC);
    rst = 1'b1;
    post("rst_req_valid", 32'(req_v), 32'd1);
    post("rst_addr", addr_w, 32'h8000_0000);
    post("rst_halt", 32'(halt_w), 32'd0);
    post("rst_commit_valid", 32'(cv_w), 32'd0);
    post("rst_commit_pc", cpc_w, 32'd0);
    post("rst_halt_code", 32'(hc_w), 32'd0);

    // a0 = 5, a0 += a0, a0 -= 10, ebreak -> a0 == 0.
    load(32'h0050_0513, 32'h00A5_0533, 32'hFF65_0513, 32'h0010_0073);
    do_reset(1'b0); model_run();
    post("model_p1_code", 32'(exp_code), 32'd1);
    post("model_p1_n", 32'(n_exp), 32'd4);
    serve(0, 0, 200);
    post("p1_commits", 32'(ncommit), 32'd4);
    post("p1_code", 32'(hc_w), 32'd1);
    post("p1_last_cpc", cpc_w, 32'h8000_000C);

    // Third word replaced by nop -> a0 == 10.
    load(32'h0050_0513, 32'h00A5_0533, 32'h0000_0013, 32'h0010_0073);
    do_reset(1'b0); model_run();
    post("model_p2_a0", mreg[10], 32'd10);
    serve(0, 0, 200);
    post("p2_commits", 32'(ncommit), 32'd4);
    post("p2_code", 32'(hc_w), 32'd2);

    // jal x1,+8 ; ebreak at +4 ; jalr x10,0(x1) at +8.
    load(32'h0080_00EF, 32'h0010_0073, 32'h0000_8567, 32'h0);
    do_reset(1'b0); model_run();
    post("model_jal_a0", mreg[10], 32'h8000_000C);
    serve(0, 0, 200);
    post("jal_second_fetch", fetch_log[1], 32'h8000_0008);
    post("jal_third_fetch", fetch_log[2], 32'h8000_0004);
    post("jal_commits", 32'(ncommit), 32'd3);
    post("jal_code", 32'(hc_w), 32'd2);

    // Backpressure on every fetch: addi x11,x0,7 ; sub x10,x11,x11 ; ebreak.
    load(32'h0070_0593, 32'h40B5_8533, 32'h0010_0073, 32'h0);
    do_reset(1'b0); model_run();
    post("model_bp_code", 32'(exp_code), 32'd1);
    serve(4, 3, 400);
    post("bp_second_fetch", fetch_log[1], 32'h8000_0004);
    post("bp_commits", 32'(ncommit), 32'd3);
    post("bp_code", 32'(hc_w), 32'd1);

    // RV32E core: addi x20,x0,1 names a missing register.
    load(32'h0010_0A13, 32'h0, 32'h0, 32'h0);
    m_nreg = 16;
    do_reset(1'b1); model_run();
    post("model_e_code", 32'(exp_code), 32'd3);
    serve(0, 0, 100);
    for (int i = 0; i < 20; i++) begin
      post("e_halt_held", 32'(halt_w), 32'd1);
      step();
    end
    post("e_code", 32'(hc_w), 32'd3);
    post("e_commits", 32'(ncommit), 32'd0);
    post("e_pc", pc_w, 32'h8000_0000);
    m_nreg = 32;

    // Reset pulsed while waiting for a response; a stale illegal word follows release.
    load(32'h0000_0013, 32'h0010_0073, 32'h0, 32'h0);
    do_reset(1'b0); model_run();
    ready = 1'b1; step(); ready = 1'b0;
    rst = 1'b0; step(); rst = 1'b1;
    step();
    rsp_valid = 1'b1; rsp_inst = 32'h0; step(); rsp_valid = 1'b0;
    step();
    post("wr_req_valid", 32'(req_v), 32'd1);
    post("wr_addr", addr_w, 32'h8000_0000);
    post("wr_halt", 32'(halt_w), 32'd0);
    post("wr_no_commit", 32'(ncommit), 32'd0);
    serve(0, 0, 200);
    post("wr_commits", 32'(ncommit), 32'd2);
    post("wr_code", 32'(hc_w), 32'd1);

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ysyx_23060303_mcore.md
# ysyx_23060303_mcore

Multi-cycle RV32I/RV32E integer core top that replaces the single-cycle core top. It fetches over a valid/ready instruction-memory interface, decodes and executes one instruction per FETCH→WAIT→EXEC pass, and writes back. It halts on `ebreak` or on an illegal or misaligned instruction. Register count and reset PC are parametrised, and the core retires at most one instruction every 3 cycles.

## Interface
- `NR_REG`, 32, architectural register count; 32 = RV32I, 16 = RV32E.
- `RESET_PC`, 32'h8000_0000, first fetch address after reset.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_rsp_valid`  in  1  instruction word valid.
- `imem_rsp_inst`  in  32  instruction word.
- `pc`  out  32  address of the instruction in flight.
- `commit_valid`  out  1  one-cycle pulse per retired instruction.
- `commit_pc`  out  32  PC of the retired instruction; valid with `commit_valid`.
- `halt`  out  1  core stopped; sticky until reset.
- `halt_code`  out  2  00 running, 01 ebreak with a0==0, 10 ebreak with a0!=0, 11 illegal or misaligned.

## Operation
- Supported instructions: `addi`, `add`, `sub`, `lui`, `auipc`, `jal`, `jalr`, `ebreak`.
  - Every other encoding is illegal.
  - Any rd, rs1 or rs2 index ≥ `NR_REG` is illegal.
- Reset values:
  - State = FETCH, `pc` = `RESET_PC`.
  - All registers = 0.
  - `commit_valid` = 0, `halt` = 0, `halt_code` = 00, `commit_pc` = 0.
- State machine:
  - FETCH: `imem_req_valid`=1. On `imem_req_valid & imem_req_ready`, go to WAIT.
  - WAIT: `imem_req_valid`=0. On `imem_rsp_valid`, latch `imem_rsp_inst` into IR and go to EXEC. A response arriving in any other state is ignored.
  - EXEC, one cycle:
    - Decode IR, read rs1/rs2 combinationally, compute the result, write rd, update `pc`, pulse `commit_valid`.
    - Go to FETCH, or to HALT for `ebreak`, illegal, or misaligned instructions.
  - HALT: no requests issued, outputs frozen. Only reset exits.
- Arithmetic:
  - All arithmetic is 32-bit modulo 2^32.
  - I-immediates and J-immediates are sign-extended.
  - `lui` writes imm<<12.
  - `auipc` writes pc + (imm<<12).
  - `jal`/`jalr` write pc+4. Targets: pc+immJ and (rs1+immI)&~1.
- x0 is hardwired to zero; writes to it are discarded.
- `ebreak` commits (`commit_valid`=1) and selects `halt_code` from x10.
- Illegal instruction, or a jump target with bit1=1:
  - No writeback, no commit, `pc` unchanged.
  - `halt_code`=11.
- Reset asserted mid-operation aborts the current state immediately. A stale response after reset release is dropped: the core is in FETCH, and a response is only taken in WAIT after a new accept.

## Timing
- Minimum 3 cycles per instruction: request accepted in FETCH cycle, response in the following cycle, EXEC in the next.
- While ready is low, `imem_req_valid` and `imem_addr` stay stable.
- `commit_valid` and `commit_pc` are registered: they assert in the cycle after EXEC, together with the updated `pc`.
- `halt` and `halt_code` rise in the same cycle as the final `commit_valid`. For illegal or misaligned halts, they rise in the cycle after EXEC.
- The register write is visible to the next instruction's EXEC; no bypass is needed.

## Structure
- Package `ysyx_23060303_pkg`:
  - Opcode, funct3 and funct7 constants.
  - FSM state enum {FETCH, WAIT, EXEC, HALT}.
  - Halt-code constants.
- Sub-module `ysyx_23060303_regfile_p`:
  - Parameter `NR_REG`; 2 asynchronous read ports, 1 synchronous write port.
  - Asynchronous active-low clear; x0 forced to zero.
- Decode, ALU and next-PC logic stay inline in the top.

## Test plan
- Reset: hold `rst`=0, then release with ready=1 → `imem_req_valid`=1, `imem_addr`=0x8000_0000, `halt`=0, `commit_valid`=0.
- Program 0x00500513, 0x00A50533, 0xFF650513, 0x00100073 → four commits at PCs 0x8000_0000..0x8000_000C, then `halt`=1 with `halt_code`=01.
  - Variant with the third word 0x00000013 → `halt_code`=10.
- 0x008000EF at 0x8000_0000 → next `imem_addr`=0x8000_0008.
  - Follow with 0x00008567 (`jalr x10,0(x1)`) then `ebreak` → `halt_code`=10, since x10=0x8000_000C.
- Backpressure: ready low for 4 cycles, then response delayed 3 cycles → `imem_addr` stable, exactly one `commit_valid`, PC advances by 4.
- `NR_REG`=16: 0x00100A13 (`addi x20,x0,1`) → `halt_code`=11, no `commit_valid`, `pc` stays 0x8000_0000, `halt` held for 20 cycles.
- Reset pulsed in WAIT, response arriving 1 cycle after release → response ignored, fetch reissued at 0x8000_0000, no commit until a fresh response.
